// File: rtl/skinny_rc_inv_seq.sv
// SKINNY inverse round-constant sequencer.
// The first run warms up by stepping the forward LFSR to rc(ROUNDS) and caches that value.
// Later runs load the cached value and emit at once.
// Constants are emitted from round ROUNDS down to 1 over a valid/ready stream.
module skinny_rc_inv_seq #(
    parameter int ROUNDS = 56
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       flush,
    output logic [5:0] rc_out,
    output logic [5:0] rc_round,
    output logic       rc_valid,
    input  logic       rc_ready,
    output logic       rc_last,
    output logic       busy
);
    localparam logic [5:0] LAST_RND = 6'(ROUNDS);
    localparam logic [5:0] WARM_END = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] lfsr;
    logic [5:0] lfsr_nxt;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;
    logic [5:0] cache;
    logic [5:0] cache_nxt;
    logic       cache_ok;
    logic       cache_ok_nxt;

    // Forward round-constant LFSR step (encryption direction)
    function automatic logic [5:0] rc_fwd(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // Exact inverse of rc_fwd: recovers the previous round's constant
    function automatic logic [5:0] rc_inv(input logic [5:0] n);
        return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
    endfunction

    // State and datapath registers; reset also clears the cache
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= '0;
            cnt      <= '0;
            cache    <= '0;
            cache_ok <= 1'b0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            cnt      <= cnt_nxt;
            cache    <= cache_nxt;
            cache_ok <= cache_ok_nxt;
        end
    end

    // Next-state logic; flush wins over everything and keeps the cache
    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        cnt_nxt      = cnt;
        cache_nxt    = cache;
        cache_ok_nxt = cache_ok;
        if (flush) begin
            state_nxt = IDLE;
            lfsr_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cache_ok) begin
                            lfsr_nxt  = cache;
                            cnt_nxt   = LAST_RND;
                            state_nxt = EMIT;
                        end else begin
                            lfsr_nxt  = '0;
                            cnt_nxt   = '0;
                            state_nxt = WARM;
                        end
                    end
                end
                WARM: begin
                    lfsr_nxt = rc_fwd(lfsr);
                    cnt_nxt  = cnt + 6'd1;
                    if (cnt == WARM_END) begin
                        cache_nxt    = rc_fwd(lfsr);
                        cache_ok_nxt = 1'b1;
                        cnt_nxt      = LAST_RND;
                        state_nxt    = EMIT;
                    end
                end
                EMIT: begin
                    if (rc_ready) begin
                        if (cnt > 6'd1) begin
                            lfsr_nxt = rc_inv(lfsr);
                            cnt_nxt  = cnt - 6'd1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs depend on registered state only, never on rc_ready; they read zero outside EMIT
    always_comb begin
        rc_valid = (state == EMIT);
        rc_out   = rc_valid ? lfsr : 6'd0;
        rc_round = rc_valid ? cnt : 6'd0;
        rc_last  = rc_valid && (cnt == 6'd1);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_skinny_rc_inv_seq.sv
// Directed bench for skinny_rc_inv_seq: one instance with 56 rounds and one with 48 rounds.
module tb_skinny_rc_inv_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       flush;
    logic       rc_ready;
    logic [5:0] rc_out;
    logic [5:0] rc_round;
    logic       rc_valid;
    logic       rc_last;
    logic       busy;

    logic       start_b;
    logic       flush_b;
    logic       rdy_b;
    logic [5:0] out_b;
    logic [5:0] round_b;
    logic       valid_b;
    logic       last_b;
    logic       busy_b;

    int n_assert = 0;
    int n_fail   = 0;

    // rc(i) for i = 0..56: the forward LFSR state after i steps from seed 0x00
    logic [5:0] rc_tab [0:56];

    skinny_rc_inv_seq #(.ROUNDS(56)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .rc_out(rc_out), .rc_round(rc_round), .rc_valid(rc_valid),
        .rc_ready(rc_ready), .rc_last(rc_last), .busy(busy)
    );

    skinny_rc_inv_seq #(.ROUNDS(48)) dut48 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .flush(flush_b),
        .rc_out(out_b), .rc_round(round_b), .rc_valid(valid_b),
        .rc_ready(rdy_b), .rc_last(last_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] inv_ref(input logic [5:0] n);
        return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
    endfunction

    // Pulse start on the 56-round instance, check latency, then take the full sequence with ready high
    task automatic run_a(input int exp_lat);
        int lat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
        lat = 1;
        while (!rc_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        if (!rc_valid) return;
        for (int k = 56; k >= 1; k--) begin
            check("valid", rc_valid, 1);
            check("rc_out", rc_out, rc_tab[k]);
            check("rc_round", rc_round, k);
            check("rc_last", rc_last, (k == 1));
            if (k == 1) check("inv_selfcheck", inv_ref(rc_out), 0);
            @(negedge clk);
        end
        check("valid_drop", rc_valid, 0);
        check("busy_fall", busy, 0);
        check("idle_out", rc_out, 0);
    endtask

    initial begin
        int k;
        int cyc;
        int lat;
        bit r;
        bit stalled;
        bit done;
        logic [5:0] prev_out;
        logic [5:0] prev_round;

        rc_tab = '{6'h00,
                   6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
                   6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
                   6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
                   6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
                   6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
                   6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04,
                   6'h09, 6'h13, 6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A};

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        rc_ready = 1'b1;
        start_b  = 1'b0;
        flush_b  = 1'b0;
        rdy_b    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rc_valid, 0);
        check("rst_out", rc_out, 0);
        check("rst_round", rc_round, 0);
        check("rst_last", rc_last, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold start: 57-cycle latency, full 56-constant sequence
        run_a(57);
        // Back-to-back cached start
        run_a(1);

        // Flush during EMIT at round 30
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s5_valid", rc_valid, 1);
        k = 56;
        while (k > 30) begin
            check("s5_out", rc_out, rc_tab[k]);
            @(negedge clk);
            k--;
        end
        check("s5_round30", rc_round, 30);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("s5_flush_valid", rc_valid, 0);
        check("s5_flush_busy", busy, 0);
        check("s5_flush_round", rc_round, 0);
        run_a(1);

        // Reset mid-EMIT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_pre_valid", rc_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s6_valid", rc_valid, 0);
        check("s6_out", rc_out, 0);
        check("s6_round", rc_round, 0);
        check("s6_last", rc_last, 0);
        check("s6_busy", busy, 0);
        run_a(57);

        // Flush during WARM needs a cold block: reset again, then flush at warm cycle 10
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("s4_warm_busy", busy, 1);
        check("s4_warm_valid", rc_valid, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("s4_flush_busy", busy, 0);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("s4_flush_prio", busy, 0);
        run_a(57);

        // 48-round instance with backpressure (cold since the last reset)
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 1;
        while (!valid_b && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b_latency", lat, 49);
        k = 48;
        cyc = 0;
        stalled = 1'b0;
        done = 1'b0;
        prev_out = '0;
        prev_round = '0;
        while (!done && cyc < 1000) begin
            check("b_valid", valid_b, 1);
            check("b_out", out_b, rc_tab[k]);
            check("b_round", round_b, k);
            check("b_last", last_b, (k == 1));
            if (stalled) begin
                check("b_hold_out", out_b, prev_out);
                check("b_hold_round", round_b, prev_round);
            end
            r = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rdy_b = r;
            prev_out = out_b;
            prev_round = round_b;
            stalled = !r;
            if (r) begin
                if (k == 1) done = 1'b1;
                else k--;
            end
            @(negedge clk);
            cyc++;
        end
        check("b_done", done, 1);
        check("b_valid_drop", valid_b, 0);
        check("b_busy_fall", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/skinny_rc_inv_seq.md
# skinny_rc_inv_seq

Inverse-direction round-constant sequencer for the SKINNY tweakable block cipher used in decryption. It produces the 6-bit round constants in reverse round order (round ROUNDS down to 1) over a valid/ready stream. The decryption round pipeline applies each constant with the same XOR constant-addition stage used for encryption, since that stage is self-inverse. On the first run the block warms up by stepping the forward LFSR; it caches the final constant so later runs start emitting immediately.

## Interface
- ROUNDS, 56, number of cipher rounds; legal range 1..62.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a reverse sequence; honoured only in IDLE.
- flush  input  1  abort the current sequence and return to IDLE; cache is kept.
- rc_out  output  6  round constant in roundcst format: bits 3:0 go to row 0, bits 5:4 to row 1.
- rc_round  output  6  round index of rc_out, from ROUNDS down to 1.
- rc_valid  output  1  rc_out and rc_round are valid.
- rc_ready  input  1  consumer accepts the constant when rc_valid and rc_ready are both high.
- rc_last  output  1  high together with rc_valid when rc_round == 1.
- busy  output  1  high in WARM or EMIT.

## Operation
- Forward LFSR step: next = {rc[4:0], rc[5]^rc[4]^1}. Seed is 0x00. rc(i) is the state after i steps, so rc(1)=0x01 and rc(2)=0x03.
- Inverse step: prev = {n[0]^n[5]^1, n[5:1]}.
- Registers:
  - lfsr[5:0]
  - cnt[5:0]
  - cache[5:0]
  - cache_ok
  - state, one of IDLE, WARM, EMIT
- IDLE:
  - start=1 and cache_ok=0: lfsr<=0, cnt<=0, go to WARM.
  - start=1 and cache_ok=1: lfsr<=cache, cnt<=ROUNDS, go to EMIT.
- WARM:
  - Each cycle: lfsr<=fwd(lfsr), cnt<=cnt+1.
  - When cnt==ROUNDS-1: also cache<=fwd(lfsr), cache_ok<=1, cnt<=ROUNDS, go to EMIT.
  - start is ignored.
- EMIT:
  - rc_valid=1, rc_out=lfsr, rc_round=cnt.
  - On handshake with cnt>1: lfsr<=inv(lfsr), cnt<=cnt-1.
  - On handshake with cnt==1: go to IDLE.
  - When rc_ready=0: hold all outputs stable, with no change to lfsr or cnt.
  - start is ignored.
- flush: in any state, go to IDLE next cycle; lfsr and cnt are cleared. If start and flush are both high, flush has priority.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, lfsr=0, cnt=0, cache=0, cache_ok=0.
  - All outputs 0: rc_out=0, rc_round=0, rc_valid=0, rc_last=0, busy=0.
- Outputs are driven from registers and state only. rc_valid, rc_out, rc_round and rc_last have no combinational path from rc_ready.
- In IDLE, rc_out and rc_round read 0.
- All arithmetic is 6-bit unsigned; cnt never wraps.

## Timing
- Cold start (start at edge t):
  - WARM occupies edges t+1 .. t+ROUNDS.
  - First rc_valid is visible after edge t+ROUNDS.
  - Latency: ROUNDS+1 cycles from start to first valid.
- Cached start: rc_valid is high the cycle after start (latency 1).
- With rc_ready held high: one constant per cycle, ROUNDS consecutive cycles. rc_valid drops the cycle after the rc_last handshake.
- Back-to-back runs: a start arriving in the cycle after the last handshake is accepted. Minimum gap is 1 IDLE cycle.
- busy:
  - Rises the cycle after an accepted start.
  - Falls the cycle after the final handshake or after flush.
- Self-check: after the round-1 handshake, inv(lfsr) must equal 0x00. A bench assertion covers this; no RTL port.

## Test plan
1. Reset, then start with ROUNDS=56 and rc_ready=1 -> no rc_valid for 56 cycles, then 56 constants in this order:
   - first constants: 0x0A (round 56), 0x25, 0x32, 0x19
   - ending with 0x07, 0x03, 0x01 (round 1)
   - rc_last high only on 0x01
2. Second start after scenario 1 -> rc_valid is high 1 cycle after start with rc_out=0x0A; the sequence is identical to scenario 1.
3. ROUNDS=48, random rc_ready backpressure -> sequence begins 0x04 (round 48), 0x22, 0x11, 0x08.
   - rc_out and rc_round are held stable during every ready-low cycle.
   - No constant is skipped or duplicated.
4. flush during WARM at cycle 10, then start again -> returns to IDLE with cache_ok still 0; the full cold warm-up repeats and produces a correct sequence.
5. flush during EMIT at round 30 -> rc_valid is 0 the next cycle. A following start emits from round 56 with 0x0A, because the cache was retained.
6. rst_n low mid-EMIT -> all outputs are 0 the next cycle and cache_ok is cleared; the next start performs a cold warm-up.
